// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction/data) arbiter onto a single memory command port.
// One transaction outstanding; data favoured with bounded instruction starvation.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                err
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             owner_i;
  logic             pick_i;
  logic             pick_d;
  logic             fwd;

  // Grant decision: same-cycle, only in IDLE and never while reset is held.
  always_comb begin
    pick_i = 1'b0;
    pick_d = 1'b0;
    if (state == IDLE && !reset) begin
      if (i_req && (!d_req || starve_cnt == STARVE_LIM)) pick_i = 1'b1;
      else if (d_req)                                    pick_d = 1'b1;
    end
  end

  assign i_gnt = pick_i;
  assign d_gnt = pick_d;

  // Responses are forwarded only while waiting for one; the owner gets it.
  assign fwd      = (state == WAIT) && mem_rvalid;
  assign i_rvalid = fwd && owner_i;
  assign d_rvalid = fwd && !owner_i;
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

  assign mem_req = (state == ISSUE);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      owner_i    <= 1'b0;
      err        <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      // Any response outside WAIT (including alongside mem_ready) is spurious.
      if (mem_rvalid && state != WAIT) err <= 1'b1;
      case (state)
        IDLE: begin
          if (pick_i) begin
            owner_i    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= i_addr;
            mem_wdata  <= '0;
            mem_wstrb  <= STRB_W'(0);
            starve_cnt <= '0;
            state      <= ISSUE;
          end else if (pick_d) begin
            owner_i    <= 1'b0;
            mem_we     <= d_we;
            mem_addr   <= d_addr;
            mem_wdata  <= d_wdata;
            mem_wstrb  <= d_wstrb;
            if (!i_req)                        starve_cnt <= '0;
            else if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + CNT_W'(1);
            state      <= ISSUE;
          end
        end
        ISSUE:   if (mem_ready)  state <= WAIT;
        WAIT:    if (mem_rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
